// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered power-up release controller for several reset domains.
// Once nReset is released, each domain is let out of reset one at a time in
// index order.  A settling delay precedes every release, then the domain's
// Ready acknowledge is awaited for a bounded time.  A domain that never
// acknowledges is flagged in FaultMask and the sequence moves on regardless.
// In RUN a Request shuts the domains down in reverse order, one per clock,
// and then restarts the power-up sequence from domain 0.
//
// Ports:
//   nReset    - asynchronous active-low board reset
//   Clk       - system clock, all state changes on the rising edge
//   Request   - synchronous re-sequence request, honoured only in RUN
//   Ready     - per-domain acknowledge, bit i high means domain i is up
//   Output    - per-domain release, 1 lets the domain run (bit 0 first)
//   Done      - every domain released and either acknowledged or faulted
//   FaultMask - sticky per-domain timeout flags, cleared by a re-sequence
//
// Parameters:
//   Stages  - number of sequenced domains (>= 1)
//   n       - width of the delay/timeout counter
//   w       - width of the stage index, 2**w must be >= Stages
//   Delay   - settling cycles before each release
//   Timeout - cycles to wait for Ready before flagging a fault
module reset_sequencer #(
  parameter int unsigned  Stages  = 4,
  parameter int unsigned  n       = 13,
  parameter int unsigned  w       = 2,
  parameter logic [n-1:0] Delay   = 13'd4883,
  parameter logic [n-1:0] Timeout = 13'd8191
) (
  input  logic              nReset,
  input  logic              Clk,
  input  logic              Request,
  input  logic [Stages-1:0] Ready,
  output logic [Stages-1:0] Output,
  output logic              Done,
  output logic [Stages-1:0] FaultMask
);

  localparam int unsigned LastStage = Stages - 1;
  localparam logic [w-1:0] last_idx = w'(LastStage);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_ACK  = 2'd1,
    ST_RUN  = 2'd2,
    ST_SHUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [w-1:0]      idx_q, idx_d;
  logic [n-1:0]      count_q, count_d;
  logic [Stages-1:0] output_d;
  logic              done_d;
  logic [Stages-1:0] fault_d;

  logic              count_zero;
  logic              stage_ready;

  assign count_zero  = (count_q == '0);
  assign stage_ready = Ready[idx_q];

  // State and registered outputs; reset drops every release line at once.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_WAIT;
      idx_q     <= '0;
      count_q   <= Delay;
      Output    <= '0;
      Done      <= 1'b0;
      FaultMask <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      Output    <= output_d;
      Done      <= done_d;
      FaultMask <= fault_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    output_d = Output;
    done_d   = Done;
    fault_d  = FaultMask;

    case (state_q)
      // Settle, then release the current domain and arm the ack timeout.
      ST_WAIT: begin
        if (count_zero) begin
          output_d[idx_q] = 1'b1;
          count_d         = Timeout;
          state_d         = ST_ACK;
        end else begin
          count_d = count_q - n'(1);
        end
      end

      // Ready wins over an expiring timeout on the same edge; a timeout
      // flags the domain but never stalls the sequence.
      ST_ACK: begin
        if (stage_ready || count_zero) begin
          if (!stage_ready) begin
            fault_d[idx_q] = 1'b1;
          end
          if (idx_q == last_idx) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + w'(1);
            count_d = Delay;
            state_d = ST_WAIT;
          end
        end else begin
          count_d = count_q - n'(1);
        end
      end

      // Steady state: Ready changes are ignored, only Request matters.
      ST_RUN: begin
        if (Request) begin
          done_d  = 1'b0;
          fault_d = '0;
          idx_d   = last_idx;
          state_d = ST_SHUT;
        end
      end

      // Reverse shutdown, one domain per edge, then a full restart.
      ST_SHUT: begin
        output_d[idx_q] = 1'b0;
        if (idx_q == '0) begin
          count_d = Delay;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q - w'(1);
        end
      end

      default: begin
        idx_d   = '0;
        count_d = Delay;
        state_d = ST_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with Stages=4, Delay=4, Timeout=6.
// Edges are counted from nReset deassertion; outputs are sampled 1 time unit
// after each rising edge.
module tb_reset_sequencer;

  logic       nReset;
  logic       Clk;
  logic       Request;
  logic [3:0] Ready;
  logic [3:0] Output;
  logic       Done;
  logic [3:0] FaultMask;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  reset_sequencer #(
    .Stages (4),
    .n      (13),
    .w      (2),
    .Delay  (13'd4),
    .Timeout(13'd6)
  ) dut (
    .nReset   (nReset),
    .Clk      (Clk),
    .Request  (Request),
    .Ready    (Ready),
    .Output   (Output),
    .Done     (Done),
    .FaultMask(FaultMask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    edge_cnt++;
  endtask

  task automatic run_to(input int e);
    while (edge_cnt < e) tick();
  endtask

  task automatic expect_at(input int e, input string tag, input logic [3:0] out,
                           input logic done, input logic [3:0] fm);
    run_to(e);
    check({tag, ".Output"},    32'(Output),    32'(out));
    check({tag, ".Done"},      32'(Done),      32'(done));
    check({tag, ".FaultMask"}, 32'(FaultMask), 32'(fm));
  endtask

  // Hold reset for a few clocks, verify the reset state, release on a falling edge.
  task automatic apply_reset(input string tag);
    nReset  = 1'b0;
    Request = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check({tag, ".rst.Output"},    32'(Output),    32'h0);
    check({tag, ".rst.Done"},      32'(Done),      32'h0);
    check({tag, ".rst.FaultMask"}, 32'(FaultMask), 32'h0);
    @(negedge Clk);
    nReset   = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    nReset  = 1'b0;
    Request = 1'b0;
    Ready   = 4'b1111;

    // All domains acknowledge immediately: releases 6 edges apart.
    apply_reset("s1");
    expect_at(4,  "s1.e4",  4'b0000, 1'b0, 4'b0000);
    expect_at(5,  "s1.e5",  4'b0001, 1'b0, 4'b0000);
    expect_at(10, "s1.e10", 4'b0001, 1'b0, 4'b0000);
    expect_at(11, "s1.e11", 4'b0011, 1'b0, 4'b0000);
    expect_at(16, "s1.e16", 4'b0011, 1'b0, 4'b0000);
    expect_at(17, "s1.e17", 4'b0111, 1'b0, 4'b0000);
    expect_at(22, "s1.e22", 4'b0111, 1'b0, 4'b0000);
    expect_at(23, "s1.e23", 4'b1111, 1'b0, 4'b0000);
    expect_at(24, "s1.e24", 4'b1111, 1'b1, 4'b0000);

    // Ready drop in RUN is ignored.
    Ready = 4'b1011;
    expect_at(30, "s6.e30", 4'b1111, 1'b1, 4'b0000);

    // Request pulse mid-sequence is ignored.
    Ready = 4'b1111;
    apply_reset("s4");
    run_to(7);
    Request = 1'b1;
    tick();
    Request = 1'b0;
    expect_at(8,  "s4.e8",  4'b0001, 1'b0, 4'b0000);
    expect_at(10, "s4.e10", 4'b0001, 1'b0, 4'b0000);
    expect_at(11, "s4.e11", 4'b0011, 1'b0, 4'b0000);
    expect_at(17, "s4.e17", 4'b0111, 1'b0, 4'b0000);
    expect_at(23, "s4.e23", 4'b1111, 1'b0, 4'b0000);
    expect_at(24, "s4.e24", 4'b1111, 1'b1, 4'b0000);
    expect_at(26, "s4.e26", 4'b1111, 1'b1, 4'b0000);

    // Domain 1 never acknowledges: fault Timeout+1 edges after its release.
    Ready = 4'b1101;
    apply_reset("s2");
    expect_at(10, "s2.e10", 4'b0001, 1'b0, 4'b0000);
    expect_at(11, "s2.e11", 4'b0011, 1'b0, 4'b0000);
    expect_at(17, "s2.e17", 4'b0011, 1'b0, 4'b0000);
    expect_at(18, "s2.e18", 4'b0011, 1'b0, 4'b0010);
    expect_at(22, "s2.e22", 4'b0011, 1'b0, 4'b0010);
    expect_at(23, "s2.e23", 4'b0111, 1'b0, 4'b0010);
    expect_at(28, "s2.e28", 4'b0111, 1'b0, 4'b0010);
    expect_at(29, "s2.e29", 4'b1111, 1'b0, 4'b0010);
    expect_at(30, "s2.e30", 4'b1111, 1'b1, 4'b0010);

    // Re-sequence from RUN: Request sampled at E=32.
    run_to(31);
    Request = 1'b1;
    tick();
    Request = 1'b0;
    expect_at(32, "s3.E",   4'b1111, 1'b0, 4'b0000);
    expect_at(33, "s3.E+1", 4'b0111, 1'b0, 4'b0000);
    expect_at(34, "s3.E+2", 4'b0011, 1'b0, 4'b0000);
    expect_at(35, "s3.E+3", 4'b0001, 1'b0, 4'b0000);
    expect_at(36, "s3.E+4", 4'b0000, 1'b0, 4'b0000);
    expect_at(40, "s3.E+8", 4'b0000, 1'b0, 4'b0000);
    expect_at(41, "s3.E+9", 4'b0001, 1'b0, 4'b0000);

    // Asynchronous reset mid-sequence, between edges 15 and 16.
    Ready = 4'b1111;
    apply_reset("s5");
    expect_at(15, "s5.e15", 4'b0011, 1'b0, 4'b0000);
    #3;
    nReset = 1'b0;
    #1;
    check("s5.async.Output",    32'(Output),    32'h0);
    check("s5.async.Done",      32'(Done),      32'h0);
    check("s5.async.FaultMask", 32'(FaultMask), 32'h0);
    @(negedge Clk);
    nReset   = 1'b1;
    edge_cnt = 0;
    expect_at(4, "s5.re4", 4'b0000, 1'b0, 4'b0000);
    expect_at(5, "s5.re5", 4'b0001, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
